conv3x3_pe: RTL and testbench
=============================

CONV3X3_PE -- requirements
Module: conv3x3_pe

Interface
REQ-001 SHALL have parameter data_width, default 32, meaning signed fixed-point word width of windows, weights, bias and result.
REQ-002 SHALL have parameter frac_bits, default 8, meaning number of fractional bits in every word.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port wload_start  input  1  meaning pulse that restarts coefficient loading.
REQ-006 SHALL have port wload_valid  input  1  meaning wload_data carries one coefficient this cycle.
REQ-007 SHALL have port wload_data  input  data_width  meaning coefficient: w0..w8 in order, then bias.
REQ-008 SHALL have port weights_loaded  output  1  meaning all 10 coefficients held; windows accepted.
REQ-009 SHALL have port input_valid  input  1  meaning data_in_0..data_in_8 hold one 3x3 window from the line buffer.
REQ-010 SHALL have ports data_in_0..data_in_8  input  data_width each  meaning window taps, index matching w index.
REQ-011 SHALL have port output_valid  output  1  meaning data_out holds one result.
REQ-012 SHALL have port data_out  output  data_width  meaning convolution result.
REQ-013 SHALL have port sat_flag  output  1  meaning sticky: some result was saturated.
REQ-014 SHALL have port drop_err  output  1  meaning sticky: a window arrived while weights_loaded was low.

Function
REQ-015 Coefficient load: 4-bit index counter; wload_start sets index 0 and clears weights_loaded in the same cycle.
REQ-016 Each wload_valid with index<10 writes coefficient[index] and increments index; index 9 write sets weights_loaded next cycle.
REQ-017 wload_valid with index=10 SHALL be ignored (no overwrite, no wrap).
REQ-018 wload_start and wload_valid in same cycle: start wins, data written to coefficient 0, index becomes 1.
REQ-019 input_valid with weights_loaded low SHALL be discarded and set drop_err; no output produced.
REQ-020 Pipeline, one window per cycle, no backpressure, fixed latency 4 cycles from accepted input_valid to output_valid.
REQ-021 Stage 1: register nine signed products, each 2*data_width bits.
REQ-022 Stage 2: register three row sums (products 0-2, 3-5, 6-8), each 2*data_width+2 bits.
REQ-023 Stage 3: register total = row sums + (bias << frac_bits), 2*data_width+4 bits.
REQ-024 Stage 4: arithmetic shift right by frac_bits (truncate toward minus infinity), saturate to signed data_width, register to data_out.
REQ-025 Saturation: values above max positive -> max positive, below min negative -> min negative; either sets sat_flag.
REQ-026 output_valid SHALL be a 4-stage delayed copy of accepted input_valid; data_out holds its last value while output_valid low.
REQ-027 Coefficient reload during in-flight windows: windows already past stage 1 use old products; later windows use new coefficients as written.

Reset
REQ-028 rst low SHALL asynchronously clear coefficients, index, all pipeline registers and valids, weights_loaded, data_out, sat_flag, drop_err to 0.
REQ-029 Reset mid-operation discards in-flight windows; no output_valid until new load completes and a window is accepted.
REQ-030 Sticky flags clear only on reset.

Configuration
REQ-031 Macro CONV3X3_PE_RELU_EN defined: stage 4 SHALL force negative saturated results to 0; sat_flag set only on positive saturation or on negative saturation before clamp.
REQ-032 Macro undefined: stage 4 outputs the signed saturated value unchanged; latency remains 4 in both builds.

Verification
REQ-033 Reset, load w=256 (1.0) x9, bias 0; window all 512 -> data_out 4608 four cycles after input_valid.
REQ-034 Same weights, bias 256, window all -512, RELU_EN undefined -> data_out -4352; RELU_EN defined -> data_out 0.
REQ-035 w4=0x7FFFFFFF only, window data_in_4=0x7FFFFFFF, back-to-back 3 windows -> three consecutive output_valid, data_out 0x7FFFFFFF, sat_flag 1.
REQ-036 input_valid pulse before any load -> no output_valid, drop_err 1; after 10-coefficient load, window accepted normally.
REQ-037 wload_start after 5 coefficients, then 10 fresh writes -> weights_loaded rises exactly once after the 10th; an 11th write is ignored.
REQ-038 rst asserted with two windows in flight -> all outputs 0 immediately, no output_valid after release.

Source files
------------

// File: rtl/conv3x3_pe.sv
// 3x3 convolution processing element: 10-coefficient loader plus a 4-stage MAC pipeline.
// Optional build macro CONV3X3_PE_RELU_EN clamps negative results to zero.
module conv3x3_pe #(
    parameter int data_width = 32,
    parameter int frac_bits  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wload_start,
    input  logic                  wload_valid,
    input  logic [data_width-1:0] wload_data,
    output logic                  weights_loaded,
    input  logic                  input_valid,
    input  logic [data_width-1:0] data_in_0,
    input  logic [data_width-1:0] data_in_1,
    input  logic [data_width-1:0] data_in_2,
    input  logic [data_width-1:0] data_in_3,
    input  logic [data_width-1:0] data_in_4,
    input  logic [data_width-1:0] data_in_5,
    input  logic [data_width-1:0] data_in_6,
    input  logic [data_width-1:0] data_in_7,
    input  logic [data_width-1:0] data_in_8,
    output logic                  output_valid,
    output logic [data_width-1:0] data_out,
    output logic                  sat_flag,
    output logic                  drop_err
);

    localparam int W  = data_width;
    localparam int PW = 2 * W;
    localparam int RW = PW + 2;
    localparam int TW = PW + 4;

    logic signed [W-1:0] din [9];

    assign din[0] = data_in_0;
    assign din[1] = data_in_1;
    assign din[2] = data_in_2;
    assign din[3] = data_in_3;
    assign din[4] = data_in_4;
    assign din[5] = data_in_5;
    assign din[6] = data_in_6;
    assign din[7] = data_in_7;
    assign din[8] = data_in_8;

    logic signed [W-1:0]  coef_q [10];
    logic signed [W-1:0]  coef_d [10];
    logic [3:0]           idx_q, idx_d;
    logic                 loaded_q, loaded_d;
    logic signed [PW-1:0] prod_q [9];
    logic signed [PW-1:0] prod_d [9];
    logic signed [W-1:0]  bias1_q, bias1_d, bias2_q, bias2_d;
    logic signed [RW-1:0] row_q [3];
    logic signed [RW-1:0] row_d [3];
    logic signed [TW-1:0] total_q, total_d;
    logic [3:0]           vld_q, vld_d;
    logic [W-1:0]         dout_q, dout_d;
    logic                 sat_q, sat_d;
    logic                 drop_q, drop_d;

    logic                 accept;
    logic signed [TW-1:0] shifted;
    logic signed [TW-1:0] max_v;
    logic signed [TW-1:0] min_v;

    always_comb begin
        coef_d   = coef_q;
        idx_d    = idx_q;
        loaded_d = loaded_q;
        prod_d   = prod_q;
        bias1_d  = bias1_q;
        bias2_d  = bias2_q;
        row_d    = row_q;
        total_d  = total_q;
        dout_d   = dout_q;
        sat_d    = sat_q;

        if (wload_start) begin
            idx_d    = '0;
            loaded_d = 1'b0;
            if (wload_valid) begin
                coef_d[0] = wload_data;
                idx_d     = 4'd1;
            end
        end else if (wload_valid && (idx_q < 4'd10)) begin
            for (int unsigned i = 0; i < 10; i++) begin
                if (idx_q == 4'(i)) coef_d[i] = wload_data;
            end
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd9) loaded_d = 1'b1;
        end

        accept = input_valid & loaded_q;
        drop_d = drop_q | (input_valid & ~loaded_q);
        vld_d  = {vld_q[2:0], accept};

        // Bias travels with its products so each window sees one coherent coefficient set.
        if (accept) begin
            for (int unsigned i = 0; i < 9; i++) begin
                prod_d[i] = din[i] * coef_q[i];
            end
            bias1_d = coef_q[9];
        end

        if (vld_q[0]) begin
            for (int unsigned r = 0; r < 3; r++) begin
                row_d[r] = RW'(prod_q[3*r]) + RW'(prod_q[3*r+1]) + RW'(prod_q[3*r+2]);
            end
            bias2_d = bias1_q;
        end

        if (vld_q[1]) begin
            total_d = TW'(row_q[0]) + TW'(row_q[1]) + TW'(row_q[2]) + (TW'(bias2_q) <<< frac_bits);
        end

        shifted        = total_q >>> frac_bits;
        max_v          = '0;
        max_v[W-2:0]   = '1;
        min_v          = '1;
        min_v[W-2:0]   = '0;

        if (vld_q[2]) begin
            if (shifted > max_v) begin
                dout_d = max_v[W-1:0];
                sat_d  = 1'b1;
            end else if (shifted < min_v) begin
`ifdef CONV3X3_PE_RELU_EN
                dout_d = '0;
`else
                dout_d = min_v[W-1:0];
`endif
                sat_d  = 1'b1;
            end else begin
`ifdef CONV3X3_PE_RELU_EN
                dout_d = shifted[TW-1] ? '0 : shifted[W-1:0];
`else
                dout_d = shifted[W-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 10; i++) coef_q[i] <= '0;
            for (int unsigned i = 0; i < 9; i++)  prod_q[i] <= '0;
            for (int unsigned i = 0; i < 3; i++)  row_q[i]  <= '0;
            idx_q    <= '0;
            loaded_q <= 1'b0;
            bias1_q  <= '0;
            bias2_q  <= '0;
            total_q  <= '0;
            vld_q    <= '0;
            dout_q   <= '0;
            sat_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            coef_q   <= coef_d;
            prod_q   <= prod_d;
            row_q    <= row_d;
            idx_q    <= idx_d;
            loaded_q <= loaded_d;
            bias1_q  <= bias1_d;
            bias2_q  <= bias2_d;
            total_q  <= total_d;
            vld_q    <= vld_d;
            dout_q   <= dout_d;
            sat_q    <= sat_d;
            drop_q   <= drop_d;
        end
    end

    assign weights_loaded = loaded_q;
    assign output_valid   = vld_q[3];
    assign data_out       = dout_q;
    assign sat_flag       = sat_q;
    assign drop_err       = drop_q;

endmodule

// File: tb/tb_conv3x3_pe.sv
// Directed scoreboard bench for conv3x3_pe (default parameters; honours CONV3X3_PE_RELU_EN).
module tb_conv3x3_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic        wload_start, wload_valid;
    logic [31:0] wload_data;
    logic        weights_loaded;
    logic        input_valid;
    logic [31:0] data_in_0, data_in_1, data_in_2, data_in_3, data_in_4;
    logic [31:0] data_in_5, data_in_6, data_in_7, data_in_8;
    logic        output_valid;
    logic [31:0] data_out;
    logic        sat_flag, drop_err;

    always #5 clk = ~clk;

    conv3x3_pe #(.data_width(32), .frac_bits(8)) dut (
        .clk(clk), .rst(rst),
        .wload_start(wload_start), .wload_valid(wload_valid), .wload_data(wload_data),
        .weights_loaded(weights_loaded), .input_valid(input_valid),
        .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2),
        .data_in_3(data_in_3), .data_in_4(data_in_4), .data_in_5(data_in_5),
        .data_in_6(data_in_6), .data_in_7(data_in_7), .data_in_8(data_in_8),
        .output_valid(output_valid), .data_out(data_out),
        .sat_flag(sat_flag), .drop_err(drop_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic signed [31:0] wts [10];
    logic signed [31:0] win [9];

    localparam logic signed [67:0] MAXV = 68'sh7FFFFFFF;
    localparam logic signed [67:0] MINV = -68'sh80000000;

`ifdef CONV3X3_PE_RELU_EN
    localparam logic [31:0] NEG_RES = 32'h0;
    localparam logic [31:0] NEG_SAT = 32'h0;
`else
    localparam logic [31:0] NEG_RES = 32'hFFFF_EF00;  // -4352
    localparam logic [31:0] NEG_SAT = 32'h8000_0000;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && output_valid === 1'b1) begin
            chk("output_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("data_out", data_out, mon_e.d);
                chk("latency", 32'(cyc), 32'(mon_e.c));
            end
        end
    end

    function automatic logic [31:0] model();
        logic signed [67:0] acc;
        logic signed [67:0] sh;
        acc = '0;
        for (int i = 0; i < 9; i++) acc += 68'(win[i]) * 68'(wts[i]);
        acc += 68'(wts[9]) <<< 8;
        sh = acc >>> 8;
        if (sh > MAXV) return 32'h7FFF_FFFF;
        if (sh < MINV) return NEG_SAT;
`ifdef CONV3X3_PE_RELU_EN
        if (sh < 0) return 32'h0;
`endif
        return sh[31:0];
    endfunction

    task automatic wl(input logic start, input logic valid, input logic [31:0] d);
        @(posedge clk); #1;
        wload_start = start;
        wload_valid = valid;
        wload_data  = d;
        @(posedge clk); #1;
        wload_start = 1'b0;
        wload_valid = 1'b0;
    endtask

    task automatic load_all(input bit combined);
        if (combined) begin
            wl(1'b1, 1'b1, wts[0]);
        end else begin
            wl(1'b1, 1'b0, 32'h0);
            wl(1'b0, 1'b1, wts[0]);
        end
        for (int i = 1; i < 10; i++) wl(1'b0, 1'b1, wts[i]);
    endtask

    task automatic send(input logic [31:0] expv, input bit push);
        @(posedge clk); #1;
        input_valid = 1'b1;
        data_in_0 = win[0]; data_in_1 = win[1]; data_in_2 = win[2];
        data_in_3 = win[3]; data_in_4 = win[4]; data_in_5 = win[5];
        data_in_6 = win[6]; data_in_7 = win[7]; data_in_8 = win[8];
        if (push) exp_q.push_back('{expv, cyc + 4});
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        input_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; wload_start = 1'b0; wload_valid = 1'b0; wload_data = '0;
        input_valid = 1'b0;
        data_in_0 = '0; data_in_1 = '0; data_in_2 = '0; data_in_3 = '0; data_in_4 = '0;
        data_in_5 = '0; data_in_6 = '0; data_in_7 = '0; data_in_8 = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_output_valid", 32'(output_valid), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_weights_loaded", 32'(weights_loaded), 32'd0);
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        rst = 1'b1;

        // Window before any load is dropped.
        for (int i = 0; i < 9; i++) win[i] = 32'sd512;
        send(32'h0, 1'b0);
        idle(6);
        chk("drop_err_set", 32'(drop_err), 32'd1);
        chk("loaded_before_load", 32'(weights_loaded), 32'd0);

        // Aborted load, restart, 10 writes, an ignored 11th.
        for (int i = 0; i < 9; i++) wts[i] = 32'sd256;
        wts[9] = 32'sd0;
        wl(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) wl(1'b0, 1'b1, 32'd999);
        chk("loaded_after_5", 32'(weights_loaded), 32'd0);
        wl(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) wl(1'b0, 1'b1, wts[i]);
        chk("loaded_after_9", 32'(weights_loaded), 32'd0);
        wl(1'b0, 1'b1, wts[9]);
        chk("loaded_after_10", 32'(weights_loaded), 32'd1);
        wl(1'b0, 1'b1, 32'h0000_7777);
        chk("loaded_after_11", 32'(weights_loaded), 32'd1);
        send(32'd4608, 1'b1);
        idle(6);

        // Start and valid together; bias 1.0, negative window.
        wts[9] = 32'sd256;
        load_all(1'b1);
        for (int i = 0; i < 9; i++) win[i] = -32'sd512;
        send(NEG_RES, 1'b1);
        idle(6);

        // Random small coefficients and windows, back to back.
        for (int i = 0; i < 10; i++) wts[i] = $signed(32'($urandom_range(2047))) - 32'sd1024;
        load_all(1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 9; i++) win[i] = $signed(32'($urandom_range(8191))) - 32'sd4096;
            send(model(), 1'b1);
        end
        idle(6);
        chk("sat_flag_clear", 32'(sat_flag), 32'd0);

        // Saturation in both directions.
        for (int i = 0; i < 10; i++) wts[i] = 32'sd0;
        wts[4] = 32'sh7FFF_FFFF;
        load_all(1'b0);
        for (int i = 0; i < 9; i++) win[i] = 32'sd0;
        win[4] = 32'sh7FFF_FFFF;
        for (int k = 0; k < 3; k++) send(32'h7FFF_FFFF, 1'b1);
        win[4] = 32'sh8000_0001;
        send(NEG_SAT, 1'b1);
        idle(6);
        chk("sat_flag_set", 32'(sat_flag), 32'd1);

        // Reset with two windows in flight.
        for (int i = 0; i < 9; i++) wts[i] = 32'sd256;
        wts[9] = 32'sd0;
        load_all(1'b0);
        for (int i = 0; i < 9; i++) win[i] = 32'sd100;
        send(32'd900, 1'b1);
        send(32'd900, 1'b1);
        @(posedge clk); #3;
        input_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_output_valid", 32'(output_valid), 32'd0);
        chk("midrst_data_out", data_out, 32'd0);
        chk("midrst_weights_loaded", 32'(weights_loaded), 32'd0);
        chk("midrst_sat_flag", 32'(sat_flag), 32'd0);
        chk("midrst_drop_err", 32'(drop_err), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk); #2;
        rst = 1'b1;
        repeat (10) @(posedge clk); #1;
        send(32'h0, 1'b0);
        idle(8);
        chk("drop_after_reset", 32'(drop_err), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
